// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Posted-write FIFO between the core data port and the data memory. The
//   core issues one store per cycle. Stores drain to memory under a
//   valid/ready handshake. The core is stalled only when the buffer is full.
//   Loads see the youngest buffered store to the same word, so they never
//   read stale memory.
//
//   Optional feature: define WBUF_COALESCE_EN to merge a store into the
//   youngest entry when both address the same word.
//
// Parameters
//   DEPTH  number of buffered stores (power of two, 2..16)
//   AW/DW  address / data width
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   memwrite, dataadr,    core store request, byte address (also used as the
//   writedata             load lookup address), store data
//   stall                 core must hold its store and PC
//   fwd_hit, fwd_data     load forwarding result (data is 0 on a miss)
//   mem_we, mem_addr,     head entry towards memory (addr/data are 0 when
//   mem_wdata, mem_ready  empty); the transfer happens on mem_we & mem_ready
//   empty                 no buffered stores

// Word-address comparator for one buffer entry. Byte offset bits are not
// part of the port because the compare ignores them.
module wbuf_match #(
  parameter int AW = 32
) (
  input  logic [AW-3:0] ent_word,
  input  logic [AW-3:0] core_word,
  output logic          hit
);
  assign hit = (ent_word == core_word);
endmodule

module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ent;
  logic   [PW-1:0]    head, tail, tail_m1;
  logic   [CW-1:0]    count;
  logic               full, push, pop, hit;
  logic   [DEPTH-1:0] match;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign tail_m1 = tail - PW'(1);

  // Per-entry word compare against the core address, shared by forwarding
  // and coalescing.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    wbuf_match #(.AW(AW)) u_match (
      .ent_word  (ent[g].addr[AW-1:2]),
      .core_word (dataadr[AW-1:2]),
      .hit       (match[g])
    );
  end

  assign mem_we    = ~empty;
  assign mem_addr  = empty ? '0 : ent[head].addr;
  assign mem_wdata = empty ? '0 : ent[head].data;
  assign pop       = mem_we & mem_ready;

`ifdef WBUF_COALESCE_EN
  // Merge into the youngest entry. If that entry is also the head leaving
  // this cycle, the merge would be lost, so a new entry is taken instead.
  assign hit   = memwrite & ~empty & match[tail_m1] & ~(pop && (tail_m1 == head));
  assign stall = memwrite & full & ~hit;
`else
  assign hit   = 1'b0;
  assign stall = memwrite & full;
`endif

  // A full buffer never takes a store, even if the head leaves this cycle.
  assign push = memwrite & ~full & ~hit;

  // Walk entries from oldest to youngest so the last match wins. The head
  // entry still forwards on the cycle it is popped. A store presented this
  // cycle is not in the array yet, so it is not seen.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && match[head + PW'(i)]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent[head + PW'(i)].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset. Validity comes only from count and the pointers.
  always_ff @(posedge clk) begin
    if (push) ent[tail] <= '{addr: dataadr, data: writedata};
    if (hit)  ent[tail_m1].data <= writedata;
  end
endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr, writedata;
  logic        stall, fwd_hit, mem_we, mem_ready, empty;
  logic [31:0] fwd_data, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  store_write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .stall     (stall),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [31:0] adr, wd;
    logic        rdy;
    logic        stall, hit;
    logic [31:0] fd;
    logic        we;
    logic [31:0] ma, md;
    logic        emp;
  } vec_t;

  vec_t vq[$];

  typedef struct {
    logic [31:0] a, d;
  } st_t;

  st_t sq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply inputs mid-cycle. Outputs are sampled 1 time unit later, before the
  // next rising edge commits the step.
  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic r);
    @(negedge clk);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    mem_ready = r;
    #1;
  endtask

  task automatic addv(input logic mw, input logic [31:0] adr, input logic [31:0] wd, input logic rdy,
                      input logic st, input logic h, input logic [31:0] fd, input logic we,
                      input logic [31:0] ma, input logic [31:0] md, input logic emp);
    vec_t v;
    v.mw = mw; v.adr = adr; v.wd = wd; v.rdy = rdy;
    v.stall = st; v.hit = h; v.fd = fd; v.we = we; v.ma = ma; v.md = md; v.emp = emp;
    vq.push_back(v);
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    //     mw adr       wd           rdy stall hit fd           we ma    md           emp
    addv(0, 32'h00, 32'h0,        0, 0, 0, 32'h0,        0, 32'h00, 32'h0,        1); // reset state
    addv(1, 32'h54, 32'hFFFFFFFB, 1, 0, 0, 32'h0,        0, 32'h00, 32'h0,        1); // store 84, not passed through
    addv(0, 32'h54, 32'h0,        1, 0, 1, 32'hFFFFFFFB, 1, 32'h54, 32'hFFFFFFFB, 0); // head visible, popped
    addv(0, 32'h00, 32'h0,        0, 0, 0, 32'h0,        0, 32'h00, 32'h0,        1);
    addv(1, 32'h00, 32'hA0,       0, 0, 0, 32'h0,        0, 32'h00, 32'h0,        1); // fill 0,4,8,12
    addv(1, 32'h04, 32'hA1,       0, 0, 0, 32'h0,        1, 32'h00, 32'hA0,       0);
    addv(1, 32'h08, 32'hA2,       0, 0, 0, 32'h0,        1, 32'h00, 32'hA0,       0);
    addv(1, 32'h0C, 32'hA3,       0, 0, 0, 32'h0,        1, 32'h00, 32'hA0,       0);
    addv(1, 32'h10, 32'hA4,       0, 1, 0, 32'h0,        1, 32'h00, 32'hA0,       0); // full -> stall
    addv(1, 32'h10, 32'hA4,       1, 1, 0, 32'h0,        1, 32'h00, 32'hA0,       0); // no full bypass
    addv(1, 32'h10, 32'hA4,       1, 0, 0, 32'h0,        1, 32'h04, 32'hA1,       0); // retry accepted
    addv(0, 32'h10, 32'h0,        1, 0, 1, 32'hA4,       1, 32'h08, 32'hA2,       0);
    addv(0, 32'h0E, 32'h0,        0, 0, 1, 32'hA3,       1, 32'h0C, 32'hA3,       0); // byte offset ignored
    addv(0, 32'h0C, 32'h0,        1, 0, 1, 32'hA3,       1, 32'h0C, 32'hA3,       0); // popping head forwards
    addv(0, 32'h00, 32'h0,        1, 0, 0, 32'h0,        1, 32'h10, 32'hA4,       0);
    addv(0, 32'h00, 32'h0,        0, 0, 0, 32'h0,        0, 32'h00, 32'h0,        1);
    addv(1, 32'h20, 32'h1,        0, 0, 0, 32'h0,        0, 32'h00, 32'h0,        1);
    addv(1, 32'h24, 32'h2,        0, 0, 0, 32'h0,        1, 32'h20, 32'h1,        0);
    addv(1, 32'h20, 32'h3,        0, 0, 1, 32'h1,        1, 32'h20, 32'h1,        0); // same-cycle store invisible
    addv(0, 32'h22, 32'h0,        0, 0, 1, 32'h3,        1, 32'h20, 32'h1,        0); // youngest wins
    addv(0, 32'h28, 32'h0,        0, 0, 0, 32'h0,        1, 32'h20, 32'h1,        0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].mw, vq[i].adr, vq[i].wd, vq[i].rdy);
      chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vq[i].stall});
      chk($sformatf("v%0d fwd_hit", i), {31'b0, fwd_hit}, {31'b0, vq[i].hit});
      chk($sformatf("v%0d fwd_data", i), fwd_data, vq[i].fd);
      chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vq[i].we});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vq[i].ma);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].md);
      chk($sformatf("v%0d empty", i), {31'b0, empty}, {31'b0, vq[i].emp});
    end

    // Drain the three stores above in order.
    sq = '{'{32'h20, 32'h1}, '{32'h24, 32'h2}, '{32'h20, 32'h3}};
    foreach (sq[k]) begin
      drive(0, 32'h0, 32'h0, 1);
      chk($sformatf("drain%0d we", k), {31'b0, mem_we}, 32'h1);
      chk($sformatf("drain%0d addr", k), mem_addr, sq[k].a);
      chk($sformatf("drain%0d data", k), mem_wdata, sq[k].d);
    end
    drive(0, 32'h0, 32'h0, 0);
    chk("drain empty", {31'b0, empty}, 32'h1);

    // Steady state at count=2: one push and one pop per cycle, pointers wrap.
    sq.delete();
    drive(1, 32'h100, 32'h5000, 0); sq.push_back('{32'h100, 32'h5000});
    drive(1, 32'h104, 32'h5001, 0); sq.push_back('{32'h104, 32'h5001});
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h108 + 32'(4 * k), 32'h6000 + 32'(k), 1);
      chk($sformatf("ss%0d stall", k), {31'b0, stall}, 32'h0);
      chk($sformatf("ss%0d addr", k), mem_addr, sq[0].a);
      chk($sformatf("ss%0d data", k), mem_wdata, sq[0].d);
      void'(sq.pop_front());
      sq.push_back('{32'h108 + 32'(4 * k), 32'h6000 + 32'(k)});
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 32'h0, 32'h0, 1);
      chk($sformatf("ss tail%0d addr", k), mem_addr, sq[0].a);
      chk($sformatf("ss tail%0d data", k), mem_wdata, sq[0].d);
      void'(sq.pop_front());
    end
    drive(0, 32'h0, 32'h0, 0);
    chk("ss empty", {31'b0, empty}, 32'h1);

    // Reset mid-drain discards everything.
    drive(1, 32'h200, 32'h7000, 0);
    drive(1, 32'h204, 32'h7001, 0);
    drive(1, 32'h208, 32'h7002, 0);
    drive(0, 32'h204, 32'h0, 1);
    chk("mid-drain head", mem_addr, 32'h200);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst empty", {31'b0, empty}, 32'h1);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst fwd_hit", {31'b0, fwd_hit}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 32'h204, 32'h0, 1);
      chk($sformatf("post-rst%0d mem_we", k), {31'b0, mem_we}, 32'h0);
    end

`ifdef WBUF_COALESCE_EN
    drive(1, 32'h40, 32'h5, 0);
    drive(1, 32'h40, 32'h6, 0);
    chk("co stall", {31'b0, stall}, 32'h0);
    drive(0, 32'h40, 32'h0, 1);
    chk("co addr", mem_addr, 32'h40);
    chk("co data", mem_wdata, 32'h6);
    chk("co fwd", fwd_data, 32'h6);
    drive(0, 32'h0, 32'h0, 0);
    chk("co single entry", {31'b0, empty}, 32'h1);
    for (int k = 0; k < 4; k++) drive(1, 32'h40 + 32'(4 * k), 32'(k + 1), 0);
    drive(1, 32'h4C, 32'h9, 0);
    chk("co full stall", {31'b0, stall}, 32'h0);
    drive(0, 32'h4C, 32'h0, 0);
    chk("co full fwd", fwd_data, 32'h9);
    sq = '{'{32'h40, 32'h1}, '{32'h44, 32'h2}, '{32'h48, 32'h3}, '{32'h4C, 32'h9}};
    foreach (sq[k]) begin
      drive(0, 32'h0, 32'h0, 1);
      chk($sformatf("co drain%0d addr", k), mem_addr, sq[k].a);
      chk($sformatf("co drain%0d data", k), mem_wdata, sq[k].d);
    end
    drive(0, 32'h0, 32'h0, 0);
    chk("co drain empty", {31'b0, empty}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-write FIFO between the single-cycle MIPS core's data port (memwrite/dataadr/writedata) and the data memory.
- Accepts one store per cycle, drains stores to memory under a valid/ready handshake, and stalls the core only when full.
- Forwards the youngest buffered store data to core loads, so a load never reads stale memory.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- memwrite  input  1  core store request this cycle.
- dataadr  input  AW  core byte address; used for store and load lookup.
- writedata  input  DW  core store data.
- stall  output  1  core must hold its current store and PC.
- fwd_hit  output  1  dataadr matches a buffered store.
- fwd_data  output  DW  data of youngest matching entry; 0 when fwd_hit=0.
- mem_we  output  1  head entry valid towards memory.
- mem_addr  output  AW  head entry address.
- mem_wdata  output  DW  head entry data.
- mem_ready  input  1  memory accepts head this cycle.
- empty  output  1  no buffered stores.

Behaviour:
- Storage: circular array, head/tail pointers, count register 0..DEPTH. Entries hold {addr, data}.
- Reset: count=0, head=tail=0.
  - Outputs after the reset edge: mem_we=0, empty=1, stall=0, fwd_hit=0, fwd_data=0, mem_addr=0, mem_wdata=0.
  - Reset mid-drain discards all entries; mem_we=0 from the next cycle. Reset has priority over all other events.
- Enqueue: memwrite=1 and count<DEPTH writes {dataadr, writedata} at tail; tail++ with wrap at DEPTH.
- Latency: a store accepted at edge N drives mem_we=1 from cycle N+1, if the buffer was empty.
- Dequeue: mem_we=count!=0. The transfer occurs when mem_we and mem_ready are both 1; head++ with wrap. mem_addr/mem_wdata are stable while mem_we=1 and mem_ready=0.
- mem_addr/mem_wdata = head entry when mem_we=1; 0 when empty.
- Simultaneous enqueue and dequeue with count in 1..DEPTH-1: both occur and count is unchanged.
- Full (count=DEPTH): stall=memwrite (combinational). The store is not taken, even if mem_ready=1 that cycle; no full-bypass. The core retries next cycle.
- Empty (count=0): mem_ready is ignored; a store arriving that cycle is enqueued, not passed through.
- stall=0 whenever memwrite=0.
- Forwarding is combinational on dataadr[AW-1:2] against all valid entries.
  - When several entries match, the youngest (closest to tail) wins.
  - The head entry being popped this cycle still forwards.
  - The store presented on the same cycle is not visible until the next cycle.
- Address compare ignores bits [1:0]; stored addresses are kept and driven unchanged.
- empty=count==0, registered-state derived.

Optional Feature:
- Macro: WBUF_COALESCE_EN.
- Defined, coalesce hit: memwrite=1, count!=0, and dataadr[AW-1:2] equals the tail-1 entry address, excluding that entry if it is the head being popped this cycle.
  - On a coalesce hit, the tail-1 data is overwritten with writedata; count and pointers are unchanged.
  - A coalesce hit is allowed when full: stall=memwrite & full & ~hit.
- Undefined: every accepted store takes a new entry; stall=memwrite & full.

Test Plan:
- Reset, then store adr 84 data 0xFFFFFFFB with mem_ready=1 -> next cycle mem_we=1, mem_addr=84, mem_wdata=0xFFFFFFFB; following cycle empty=1.
- mem_ready=0, stores to 0,4,8,12 -> count=4; store to 16 -> stall=1 and not enqueued.
  - Then mem_ready=1 -> drain order 0,4,8,12 with data intact.
  - The store to 16 is accepted on the first cycle stall drops.
- mem_ready=0, stores to 0x20=1, 0x24=2, 0x20=3 -> load dataadr=0x22 gives fwd_hit=1, fwd_data=3.
  - dataadr=0x28 gives fwd_hit=0, fwd_data=0.
- count=2 with mem_ready=1 and memwrite=1 each cycle for 10 cycles -> count stays 2; drain order equals issue order; pointers wrap past DEPTH correctly.
- 3 entries buffered, assert reset for 1 cycle mid-drain -> mem_we=0, empty=1 next cycle; no further writes to memory.
- WBUF_COALESCE_EN: mem_ready=0, stores 0x40=5, 0x40=6 -> count=1, drained data 6.
  - Full buffer with tail-1 address 0x4C, store 0x4C -> stall=0, tail-1 data updated.
